// File: rtl/nco_pkg.sv
// Shared definitions for the NCO configuration responder.
//   - default datapath widths and abort timeout
//   - loader control-code encodings
//   - handshake state encoding
package nco_pkg;

  localparam int unsigned NCO_FRE_W   = 32;
  localparam int unsigned NCO_PHA_W   = 32;
  localparam int unsigned NCO_OUT_W   = 16;
  localparam int unsigned NCO_TIMEOUT = 15;

  typedef enum logic [1:0] {
    CTL_IDLE    = 2'b00,
    CTL_ARM     = 2'b01,
    CTL_COMMIT  = 2'b10,
    CTL_ILLEGAL = 2'b11
  } ctl_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_APPLY = 2'b10
  } state_e;

endpackage

// File: rtl/nco_phase_acc.sv
// Phase accumulator with load/advance mux and truncated output register.
// Ports:
//   CLK, nRST   clock, asynchronous active-low reset
//   run_en      advance acc by inc when not loading
//   load        take load_inc/load_acc this cycle (overrides advance)
//   load_inc    new frequency tuning word
//   load_acc    new accumulator (phase) value
//   phase_out   registered accumulator MSBs
module nco_phase_acc
  import nco_pkg::*;
#(
  parameter int unsigned ACC_W = NCO_FRE_W,
  parameter int unsigned OUT_W = NCO_OUT_W
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             run_en,
  input  logic             load,
  input  logic [ACC_W-1:0] load_inc,
  input  logic [ACC_W-1:0] load_acc,
  output logic [OUT_W-1:0] phase_out
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] inc_q, inc_d;
  logic [OUT_W-1:0] phase_q, phase_d;

  // Load wins over advance; the sum wraps modulo 2^ACC_W.
  always_comb begin
    acc_d   = acc_q;
    inc_d   = inc_q;
    phase_d = acc_q[ACC_W-1 -: OUT_W];
    if (load) begin
      acc_d = load_acc;
      inc_d = load_inc;
    end else if (run_en) begin
      acc_d = acc_q + inc_q;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      acc_q   <= '0;
      inc_q   <= '0;
      phase_q <= '0;
    end else begin
      acc_q   <= acc_d;
      inc_q   <= inc_d;
      phase_q <= phase_d;
    end
  end

  assign phase_out = phase_q;

endmodule

// File: rtl/nco_phase_cfg_responder.sv
// Responder end of the NCO arm/commit configuration handshake. Accepts an
// arm, then a commit carrying frequency/phase words, applies them to the
// phase accumulator and reports ACK/Done; flags protocol errors.
// Ports:
//   CLK, nRST         clock, asynchronous active-low reset
//   configCtl_ctl     00 idle, 01 arm, 10 commit, 11 illegal
//   configFreqMod     frequency tuning word (sampled on commit)
//   configPhasMod     phase load value (sampled on commit)
//   run_en            accumulator advance enable
//   err_clr           clears cfg_err (a same-cycle error wins)
//   isConfigACK_ctl   high from accepted arm until Done or abort
//   isConfigDone_ctl  one-cycle pulse when the new words are active
//   phase_out         registered accumulator MSBs
//   phase_valid       set once a configuration has been applied
//   cfg_err           sticky protocol error
module nco_phase_cfg_responder
  import nco_pkg::*;
#(
  parameter int unsigned FRE_MOD_WIDTH  = NCO_FRE_W,
  parameter int unsigned PHA_MOD_WIDTH  = NCO_PHA_W,
  parameter int unsigned OUTPUT_WIDTH   = NCO_OUT_W,
  parameter int unsigned TIMEOUT_CYCLES = NCO_TIMEOUT
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [1:0]               configCtl_ctl,
  input  logic [FRE_MOD_WIDTH-1:0] configFreqMod,
  input  logic [PHA_MOD_WIDTH-1:0] configPhasMod,
  input  logic                     run_en,
  input  logic                     err_clr,
  output logic                     isConfigACK_ctl,
  output logic                     isConfigDone_ctl,
  output logic [OUTPUT_WIDTH-1:0]  phase_out,
  output logic                     phase_valid,
  output logic                     cfg_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ctl_e ctl;
  assign ctl = ctl_e'(configCtl_ctl);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [FRE_MOD_WIDTH-1:0] shadow_freq_q, shadow_freq_d;
  logic [FRE_MOD_WIDTH-1:0] shadow_pha_q, shadow_pha_d;
  logic                     ack_q, ack_d;
  logic                     done_q, done_d;
  logic                     valid_q, valid_d;
  logic                     err_q, err_d;
  logic                     err_set;
  logic                     load;

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ctl == CTL_ARM) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        unique case (ctl)
          CTL_COMMIT:  state_d = ST_APPLY;
          CTL_ILLEGAL: state_d = ST_IDLE;
          CTL_IDLE:    if (cnt_q == CNT_LAST) state_d = ST_IDLE;
          CTL_ARM:     state_d = ST_ARMED;
        endcase
      end
      ST_APPLY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Handshake, shadow, counter and error next values.
  always_comb begin
    cnt_d         = cnt_q;
    shadow_freq_d = shadow_freq_q;
    shadow_pha_d  = shadow_pha_q;
    ack_d         = ack_q;
    done_d        = 1'b0;
    valid_d       = valid_q;
    err_set       = 1'b0;
    load          = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        unique case (ctl)
          CTL_ARM: begin
            ack_d = 1'b1;
            cnt_d = '0;
          end
          CTL_COMMIT, CTL_ILLEGAL: err_set = 1'b1;
          CTL_IDLE: ;
        endcase
      end
      ST_ARMED: begin
        unique case (ctl)
          CTL_COMMIT: begin
            shadow_freq_d = configFreqMod;
            shadow_pha_d  = FRE_MOD_WIDTH'(configPhasMod);
          end
          CTL_ARM: cnt_d = '0;
          CTL_ILLEGAL: begin
            err_set = 1'b1;
            ack_d   = 1'b0;
          end
          CTL_IDLE: begin
            if (cnt_q == CNT_LAST) begin
              err_set = 1'b1;
              ack_d   = 1'b0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        endcase
      end
      ST_APPLY: begin
        load    = 1'b1;
        done_d  = 1'b1;
        ack_d   = 1'b0;
        valid_d = 1'b1;
      end
      default: ;
    endcase
    // Set has priority over clear.
    err_d = (err_q & ~err_clr) | err_set;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q         <= '0;
      shadow_freq_q <= '0;
      shadow_pha_q  <= '0;
      ack_q         <= 1'b0;
      done_q        <= 1'b0;
      valid_q       <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      shadow_freq_q <= shadow_freq_d;
      shadow_pha_q  <= shadow_pha_d;
      ack_q         <= ack_d;
      done_q        <= done_d;
      valid_q       <= valid_d;
      err_q         <= err_d;
    end
  end

  nco_phase_acc #(
    .ACC_W (FRE_MOD_WIDTH),
    .OUT_W (OUTPUT_WIDTH)
  ) u_acc (
    .CLK       (CLK),
    .nRST      (nRST),
    .run_en    (run_en),
    .load      (load),
    .load_inc  (shadow_freq_q),
    .load_acc  (shadow_pha_q),
    .phase_out (phase_out)
  );

  assign isConfigACK_ctl  = ack_q;
  assign isConfigDone_ctl = done_q;
  assign phase_valid      = valid_q;
  assign cfg_err          = err_q;

endmodule

// File: tb/tb_nco_phase_cfg_responder.sv
// Scoreboard bench for nco_phase_cfg_responder: a transaction-level model
// predicts every cycle's outputs; a monitor compares them after each edge.
module tb_nco_phase_cfg_responder;

  localparam int unsigned FW = 32;
  localparam int unsigned OW = 16;
  localparam int unsigned TO = 15;

  typedef struct packed {
    logic          ack;
    logic          done;
    logic          pv;
    logic          err;
    logic [OW-1:0] phase;
  } exp_t;

  logic          CLK;
  logic          nRST;
  logic [1:0]    configCtl_ctl;
  logic [FW-1:0] configFreqMod;
  logic [FW-1:0] configPhasMod;
  logic          run_en;
  logic          err_clr;
  logic          isConfigACK_ctl;
  logic          isConfigDone_ctl;
  logic [OW-1:0] phase_out;
  logic          phase_valid;
  logic          cfg_err;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  exp_t exp_q[$];

  nco_phase_cfg_responder dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .configCtl_ctl    (configCtl_ctl),
    .configFreqMod    (configFreqMod),
    .configPhasMod    (configPhasMod),
    .run_en           (run_en),
    .err_clr          (err_clr),
    .isConfigACK_ctl  (isConfigACK_ctl),
    .isConfigDone_ctl (isConfigDone_ctl),
    .phase_out        (phase_out),
    .phase_valid      (phase_valid),
    .cfg_err          (cfg_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference model: loader-protocol view of the responder.
  bit            m_armed, m_commit_pending, m_ack, m_done, m_pv, m_err;
  int            m_idle_cycles;
  logic [FW-1:0] m_acc, m_inc, m_new_freq, m_new_pha;
  logic [OW-1:0] m_phase;

  task automatic model_reset();
    m_armed = 0; m_commit_pending = 0; m_ack = 0; m_done = 0; m_pv = 0; m_err = 0;
    m_idle_cycles = 0;
    m_acc = '0; m_inc = '0; m_new_freq = '0; m_new_pha = '0; m_phase = '0;
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_step(input logic rstn, input logic [1:0] ctl, input logic [FW-1:0] freq,
                            input logic [FW-1:0] pha, input logic run, input logic clr);
    bit            err_now;
    logic [OW-1:0] next_phase;
    if (!rstn) begin
      model_reset();
      return;
    end
    err_now    = 0;
    next_phase = OW'(m_acc >> (FW - OW));
    if (m_commit_pending) begin
      m_acc = m_new_pha;
      m_inc = m_new_freq;
      m_done = 1; m_ack = 0; m_pv = 1;
      m_commit_pending = 0;
    end else begin
      m_done = 0;
      if (run) m_acc = m_acc + m_inc;
      if (!m_armed) begin
        if (ctl == 2'd1) begin
          m_armed = 1; m_ack = 1; m_idle_cycles = 0;
        end else if (ctl != 2'd0) begin
          err_now = 1;
        end
      end else begin
        case (ctl)
          2'd2: begin
            m_new_freq = freq; m_new_pha = pha;
            m_armed = 0; m_commit_pending = 1;
          end
          2'd1: m_idle_cycles = 0;
          2'd3: begin
            err_now = 1; m_armed = 0; m_ack = 0;
          end
          default: begin
            m_idle_cycles++;
            if (m_idle_cycles == TO) begin
              err_now = 1; m_armed = 0; m_ack = 0;
            end
          end
        endcase
      end
    end
    m_err   = (m_err && !clr) || err_now;
    m_phase = next_phase;
  endtask

  // Drive one cycle at the falling edge and queue the predicted outcome.
  task automatic drive(input logic rstn, input logic [1:0] ctl, input logic [FW-1:0] freq,
                       input logic [FW-1:0] pha, input logic run, input logic clr);
    exp_t e;
    @(negedge CLK);
    nRST          = rstn;
    configCtl_ctl = ctl;
    configFreqMod = freq;
    configPhasMod = pha;
    run_en        = run;
    err_clr       = clr;
    model_step(rstn, ctl, freq, pha, run, clr);
    e.ack = m_ack; e.done = m_done; e.pv = m_pv; e.err = m_err; e.phase = m_phase;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [1:0] ctl);
    drive(1'b1, ctl, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  // Monitor: compare DUT outputs against the queued prediction after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        cyc++;
        tests++;
        if ({isConfigACK_ctl, isConfigDone_ctl, phase_valid, cfg_err, phase_out} !== e) begin
          fails++;
          $display("FAIL cycle%0d outputs: got ack=%b done=%b pv=%b err=%b phase=%h, expected ack=%b done=%b pv=%b err=%b phase=%h",
                   cyc, isConfigACK_ctl, isConfigDone_ctl, phase_valid, cfg_err, phase_out,
                   e.ack, e.done, e.pv, e.err, e.phase);
        end
      end
    end
  end

  initial begin
    logic [1:0]    c;
    logic [FW-1:0] f, p;
    int            r;
    nRST = 1'b0; configCtl_ctl = 2'b00; configFreqMod = '0; configPhasMod = '0;
    run_en = 1'b0; err_clr = 1'b0;
    model_reset();

    drive(1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
    drive(1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
    check("reset_outputs", 32'({isConfigACK_ctl, isConfigDone_ctl, phase_valid, cfg_err, phase_out}), 32'd0);

    // First configuration: quarter-turn step, zero phase, then wrap.
    drive(1'b1, 2'd1, '0, '0, 1'b1, 1'b0);
    drive(1'b1, 2'd2, 32'h4000_0000, 32'h0, 1'b1, 1'b0);
    step(2'd0);
    step(2'd0);
    check("first_done_ack", 32'({isConfigDone_ctl, isConfigACK_ctl, phase_valid}), 32'b101);
    step(2'd0);
    check("phase_0000", 32'(phase_out), 32'h0000);
    step(2'd0);
    check("phase_4000", 32'(phase_out), 32'h4000);
    step(2'd0);
    check("phase_8000", 32'(phase_out), 32'h8000);
    step(2'd0);
    check("phase_c000", 32'(phase_out), 32'hC000);
    step(2'd0);
    check("phase_wrap", 32'(phase_out), 32'h0000);

    // Constant half-turn phase, then freeze with run_en low.
    step(2'd1);
    drive(1'b1, 2'd2, 32'h0, 32'h8000_0000, 1'b1, 1'b0);
    repeat (4) step(2'd0);
    check("phase_const", 32'(phase_out), 32'h8000);
    step(2'd1);
    drive(1'b1, 2'd2, 32'h0123_4567, 32'h1000_0000, 1'b1, 1'b0);
    repeat (5) step(2'd0);
    repeat (4) drive(1'b1, 2'd0, '0, '0, 1'b0, 1'b0);
    repeat (3) step(2'd0);

    // Commit without arm: error only, stream continues.
    step(2'd2);
    step(2'd0);
    check("commit_in_idle_err", 32'({cfg_err, isConfigACK_ctl, isConfigDone_ctl}), 32'b100);
    drive(1'b1, 2'd0, '0, '0, 1'b1, 1'b1);
    step(2'd0);
    check("err_cleared", 32'(cfg_err), 32'd0);
    drive(1'b1, 2'd3, '0, '0, 1'b1, 1'b1);
    step(2'd0);
    check("err_set_wins", 32'(cfg_err), 32'd1);
    drive(1'b1, 2'd0, '0, '0, 1'b1, 1'b1);

    // Arm then silence: abort exactly at the timeout.
    step(2'd1);
    for (int i = 0; i < int'(TO); i++) step(2'd0);
    check("ack_before_timeout", 32'({isConfigACK_ctl, cfg_err}), 32'b10);
    step(2'd0);
    check("timeout_abort", 32'({isConfigACK_ctl, cfg_err, isConfigDone_ctl}), 32'b010);
    drive(1'b1, 2'd0, '0, '0, 1'b1, 1'b1);

    // Illegal code while armed, then re-arm followed by commit.
    step(2'd1);
    step(2'd3);
    step(2'd0);
    check("illegal_abort", 32'({isConfigACK_ctl, cfg_err}), 32'b01);
    step(2'd1);
    step(2'd1);
    drive(1'b1, 2'd2, 32'h0800_0000, 32'h2000_0000, 1'b1, 1'b0);
    step(2'd1);
    step(2'd2);
    repeat (3) step(2'd0);

    // Reset while armed clears everything at once.
    step(2'd1);
    drive(1'b0, 2'd0, '0, '0, 1'b1, 1'b0);
    #1;
    check("async_reset", 32'({isConfigACK_ctl, isConfigDone_ctl, phase_valid, cfg_err, phase_out}), 32'd0);
    drive(1'b1, 2'd0, '0, '0, 1'b1, 1'b0);
    step(2'd1);
    drive(1'b1, 2'd2, 32'h0001_0000, 32'hFFFF_0000, 1'b1, 1'b0);
    repeat (4) step(2'd0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 19));
      if (r < 11)      c = 2'd0;
      else if (r < 15) c = 2'd1;
      else if (r < 19) c = 2'd2;
      else             c = 2'd3;
      f = $urandom();
      p = $urandom();
      drive(($urandom_range(0, 199) != 0), c, f, p,
            ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0));
    end

    @(posedge CLK);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
